// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, state codes,
// datapath mux selects, ALU operation classes and trap causes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_WB_ALU   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_LUI      = 4'd11;
    localparam logic [3:0] ST_AUIPC    = 4'd12;
    localparam logic [3:0] ST_TRAP     = 4'd15;

    localparam logic [1:0] SRC_A_RS1   = 2'b00;
    localparam logic [1:0] SRC_A_PC    = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    localparam logic [1:0] M2R_ALU     = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_CMP     = 2'b01;
    localparam logic [1:0] ALU_RFUNCT  = 2'b10;
    localparam logic [1:0] ALU_IFUNCT  = 2'b11;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
    } ctrl_t;

    function automatic logic is_mem_state(input logic [3:0] st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for the memory handshake; timeout is raised once the
// counter has reached MAX, i.e. after MAX consecutive not-ready cycles.
module mem_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign timeout = (count_reg == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: state register, dispatch, Moore
// output decode with memory-ready qualification, watchdog trap and retire counter.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_dbg
);
    logic [3:0]       state_reg, state_next;
    logic [1:0]       cause_reg, cause_next;
    logic             trap_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             in_mem_state;
    logic             wait_timeout;
    ctrl_t            ctrl;

    assign in_mem_state = is_mem_state(state_reg);

    mem_wait_timer #(
        .MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state_next != state_reg) || !in_mem_state),
        .en      (in_mem_state && !mem_ready),
        .timeout (wait_timeout)
    );

    // Next-state logic; cause_next only matters on the transition into TRAP.
    always_comb begin
        state_next = state_reg;
        cause_next = CAUSE_NONE;
        case (state_reg)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (wait_timeout) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_R:      state_next = ST_EXEC_R;
                    OPC_I:      state_next = ST_EXEC_I;
                    OPC_LOAD,
                    OPC_STORE:  state_next = ST_MEM_ADDR;
                    OPC_BRANCH: state_next = ST_BRANCH;
                    OPC_JAL:    state_next = ST_JAL;
                    OPC_LUI:    state_next = ST_LUI;
                    OPC_AUIPC:  state_next = ST_AUIPC;
                    default: begin
                        state_next = ST_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC: state_next = ST_WB_ALU;
            ST_MEM_ADDR: state_next = (opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_next = ST_WB_MEM;
                end else if (wait_timeout) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_next = ST_FETCH;
                end else if (wait_timeout) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL: state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: begin
                state_next = ST_TRAP;
                cause_next = CAUSE_ILLEGAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            cause_reg   <= CAUSE_NONE;
            trap_reg    <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_next == ST_TRAP) && (state_reg != ST_TRAP)) begin
                trap_reg  <= 1'b1;
                cause_reg <= cause_next;
            end
            if (ctrl.retire) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    // Output decode; memory states only commit their strobes once mem_ready is seen.
    always_comb begin
        ctrl = '0;
        case (state_reg)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.alu_src_a = SRC_A_PC;
                    ctrl.alu_src_b = SRC_B_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                end
            end
            ST_DECODE, ST_AUIPC: begin
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_RFUNCT;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_IFUNCT;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.retire  = mem_ready;
            end
            ST_WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_ALU;
                ctrl.retire     = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.retire     = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALU_CMP;
                ctrl.pc_write  = branch_cond;
                ctrl.pc_src    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            ST_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = 1'b1;
                ctrl.retire     = 1'b1;
            end
            ST_LUI: begin
                ctrl.alu_src_a = SRC_A_ZERO;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            default: ctrl = '0;
        endcase
        // A reset cycle must never let a partial access or write escape.
        if (rst) begin
            ctrl.mem_req   = 1'b0;
            ctrl.mem_we    = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.pc_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.retire    = 1'b0;
        end
    end

    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign iord          = ctrl.iord;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_src        = ctrl.pc_src;
    assign reg_write     = ctrl.reg_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign instr_retired = ctrl.retire;
    assign retired_count = retired_reg;
    assign trap          = trap_reg;
    assign trap_cause    = cause_reg;
    assign state_dbg     = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction sequences, latency,
// watchdog limit, illegal-opcode trap and reset abort.
module tb_multicycle_control_fsm;
    import riscv_ctrl_pkg::*;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_cond;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
    logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic        instr_retired;
    logic [31:0] retired_count;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_retired = 0;

    multicycle_control_fsm #(
        .MEM_WAIT_MAX (WAIT_MAX),
        .CNT_W        (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .branch_cond   (branch_cond),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_retired (instr_retired),
        .retired_count (retired_count),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_retired = 0;
    endtask

    // Runs one instruction from FETCH; memory states see low_cycles not-ready cycles.
    task automatic run_instr(input logic [6:0] op, input logic cond, input int low_cycles,
                             output int cycles, output logic [1:0] m2r_last,
                             output logic pcw_last, output logic pcs_last);
        int  lows;
        bit  done;
        opcode = op;
        branch_cond = cond;
        lows = 0;
        cycles = 0;
        done = 0;
        m2r_last = 2'b00;
        pcw_last = 1'b0;
        pcs_last = 1'b0;
        while (!done && cycles < 60) begin
            if ((state_dbg == ST_MEM_RD || state_dbg == ST_MEM_WR) && lows < low_cycles) begin
                mem_ready = 1'b0;
                lows++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            cycles++;
            if (instr_retired) begin
                done = 1;
                m2r_last = mem_to_reg;
                pcw_last = pc_write;
                pcs_last = pc_src;
            end
            step();
        end
        if (done) exp_retired++;
        check_val($sformatf("retire_seen_op%02h", op), 32'(done), 32'd1);
    endtask

    int         cyc;
    logic [1:0] m2r;
    logic       pcw, pcs;
    int         n;

    initial begin
        rst = 1'b1;
        opcode = OPC_R;
        branch_cond = 1'b0;
        mem_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_val("reset_state", 32'(state_dbg), 32'(ST_FETCH));
        check_val("reset_count", retired_count, 32'd0);
        check_val("reset_trap", 32'({trap, trap_cause}), 32'd0);

        // add: FETCH, DECODE, EXEC_R, WB_ALU
        check_val("add_fetch_irw", 32'({mem_req, iord, ir_write, pc_write}), 32'b1011);
        check_val("add_fetch_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b010100);
        step();
        check_val("add_decode", 32'({state_dbg, reg_write, alu_src_a, alu_src_b}), 32'b0001_0_10_10);
        step();
        check_val("add_exec", 32'({state_dbg, reg_write, alu_op}), 32'b0010_0_10);
        step();
        check_val("add_wb", 32'({state_dbg, reg_write, mem_to_reg, instr_retired}), 32'b0111_1_00_1);
        step();
        check_val("add_back_fetch", 32'(state_dbg), 32'(ST_FETCH));
        check_val("add_count", retired_count, 32'd1);
        exp_retired = 1;

        run_instr(OPC_LOAD, 1'b0, 3, cyc, m2r, pcw, pcs);
        check_val("lw_cycles", 32'(cyc), 32'd8);
        check_val("lw_m2r", 32'(m2r), 32'b01);

        run_instr(OPC_BRANCH, 1'b1, 0, cyc, m2r, pcw, pcs);
        check_val("beq_t_cycles", 32'(cyc), 32'd3);
        check_val("beq_t_pc", 32'({pcw, pcs}), 32'b11);
        run_instr(OPC_BRANCH, 1'b0, 0, cyc, m2r, pcw, pcs);
        check_val("beq_nt_cycles", 32'(cyc), 32'd3);
        check_val("beq_nt_pcw", 32'(pcw), 32'd0);

        run_instr(OPC_LUI, 1'b0, 0, cyc, m2r, pcw, pcs);
        check_val("lui_cycles", 32'(cyc), 32'd4);
        run_instr(OPC_JAL, 1'b0, 0, cyc, m2r, pcw, pcs);
        check_val("jal_cycles", 32'(cyc), 32'd3);
        check_val("jal_wb", 32'({m2r, pcw, pcs}), 32'b1011);
        run_instr(OPC_STORE, 1'b0, 0, cyc, m2r, pcw, pcs);
        check_val("sw_cycles", 32'(cyc), 32'd4);
        run_instr(OPC_STORE, 1'b0, 2, cyc, m2r, pcw, pcs);
        check_val("sw_wait_cycles", 32'(cyc), 32'd6);
        check_val("count_after_mix", retired_count, 32'd8);
        check_val("count_model", retired_count, 32'(exp_retired));

        // illegal opcode traps after DECODE and is sticky
        opcode = 7'h7F;
        mem_ready = 1'b1;
        step();
        check_val("ill_decode", 32'(state_dbg), 32'(ST_DECODE));
        step();
        check_val("ill_trap", 32'({state_dbg, trap, trap_cause}), 32'b1111_1_01);
        mem_ready = 1'b1;
        step();
        step();
        check_val("ill_sticky", 32'({state_dbg, trap, trap_cause, mem_req}), 32'b1111_1_01_0);
        do_reset();
        check_val("ill_reset", 32'({state_dbg, trap, trap_cause}), 32'd0);

        // watchdog: ready held low in FETCH
        opcode = OPC_R;
        mem_ready = 1'b0;
        n = 0;
        while (state_dbg == ST_FETCH && n < 40) begin
            n++;
            step();
        end
        check_val("wd_fetch_cycles", 32'(n), 32'(WAIT_MAX + 1));
        check_val("wd_trap", 32'({state_dbg, trap, trap_cause}), 32'b1111_1_10);
        do_reset();

        // ready arrives exactly on the limit cycle
        mem_ready = 1'b0;
        repeat (WAIT_MAX) step();
        mem_ready = 1'b1;
        #1;
        check_val("wd_limit_fetch", 32'({state_dbg, ir_write}), 32'b0000_1);
        step();
        check_val("wd_limit_ok", 32'({state_dbg, trap}), 32'b0001_0);
        do_reset();

        // reset while waiting in MEM_WR
        opcode = OPC_STORE;
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        check_val("rst_mw_state", 32'({state_dbg, mem_we, mem_req}), 32'b0110_1_1);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_val("rst_mw_strobes", 32'({mem_we, mem_req, instr_retired}), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_val("rst_mw_after", 32'({state_dbg, trap}), 32'd0);
        check_val("rst_mw_count", retired_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
